// File: rtl/down_counter_sched_pkg.sv
// Shared types and default sizing for the time-shared down counter scheduler.
package down_counter_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 8;

    // Width of a requester index; kept at least 1 bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/down_counter_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module rr_arbiter
    import down_counter_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int PW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [PW-1:0]   o_idx,
    output logic            o_any
);

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!o_any && i_req[(int'(i_ptr) + k) % NREQ]) begin
                o_any = 1'b1;
                o_idx = PW'((int'(i_ptr) + k) % NREQ);
                o_gnt[(int'(i_ptr) + k) % NREQ] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/down_counter_sched.sv
// One W-bit down counter time-shared among NREQ requesters with round-robin grant.
// Optional abort port enabled by defining DOWN_CNT_SCHED_ABORT_EN.
module down_counter_sched
    import down_counter_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] load_val,
`ifdef DOWN_CNT_SCHED_ABORT_EN
    input  logic [NREQ-1:0]   abort,
`endif
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic [W-1:0]      q
);

    localparam int PW = idx_w(NREQ);

    state_t          r_state, w_state_nxt;
    logic [NREQ-1:0] r_gnt, w_gnt_nxt;
    logic [NREQ-1:0] r_done, w_done_nxt;
    logic [W-1:0]    r_q, w_q_nxt;
    logic [PW-1:0]   r_ptr, w_ptr_nxt;
    logic [PW-1:0]   r_win, w_win_nxt;

    logic [NREQ-1:0] w_arb_gnt;
    logic [PW-1:0]   w_arb_idx;
    logic            w_arb_any;
    logic            w_abort;

    function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] p);
        if (int'(p) == NREQ - 1)
            return '0;
        return p + 1'b1;
    endfunction

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx),
        .o_any (w_arb_any)
    );

`ifdef DOWN_CNT_SCHED_ABORT_EN
    // Only the current owner's abort bit matters.
    assign w_abort = abort[r_win];
`else
    assign w_abort = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_done_nxt  = '0;
        w_q_nxt     = r_q;
        w_ptr_nxt   = r_ptr;
        w_win_nxt   = r_win;
        case (r_state)
            IDLE: begin
                if (w_arb_any) begin
                    w_state_nxt = RUN;
                    w_gnt_nxt   = w_arb_gnt;
                    w_win_nxt   = w_arb_idx;
                    w_q_nxt     = load_val[int'(w_arb_idx)*W +: W];
                end
            end
            RUN: begin
                if (w_abort) begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                    w_q_nxt     = '0;
                    w_ptr_nxt   = ptr_after(r_win);
                end else if (r_q == '0) begin
                    // Owner's one-hot grant becomes its done pulse.
                    w_state_nxt = IDLE;
                    w_done_nxt  = r_gnt;
                    w_gnt_nxt   = '0;
                    w_ptr_nxt   = ptr_after(r_win);
                end else begin
                    w_q_nxt = r_q - 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_done  <= '0;
            r_q     <= '0;
            r_ptr   <= '0;
            r_win   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_done  <= w_done_nxt;
            r_q     <= w_q_nxt;
            r_ptr   <= w_ptr_nxt;
            r_win   <= w_win_nxt;
        end
    end

    assign gnt  = r_gnt;
    assign done = r_done;
    assign busy = |r_gnt;
    assign q    = r_q;

endmodule

// File: tb/tb_down_counter_sched.sv
// Directed self-checking bench for down_counter_sched (NREQ=4, W=8).
module tb_down_counter_sched;

    localparam int NREQ = 4;
    localparam int W    = 8;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] load_val;
    logic [NREQ-1:0]   abort;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              busy;
    logic [W-1:0]      q;

    int errors = 0;
    int checks = 0;

    down_counter_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .load_val (load_val),
`ifdef DOWN_CNT_SCHED_ABORT_EN
        .abort    (abort),
`endif
        .gnt      (gnt),
        .done     (done),
        .busy     (busy),
        .q        (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_len(input int idx, input int len);
        load_val[idx*W +: W] = W'(len);
    endtask

    initial begin
        logic [NREQ-1:0] exp_g;
        rst      = 1'b1;
        req      = 4'b1111;
        load_val = '0;
        abort    = '0;
        #2 rst = 1'b0;

        // Reset held with every requester asking
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_gnt", 32'(gnt), 32'h0);
            check("rst_done", 32'(done), 32'h0);
            check("rst_q", 32'(q), 32'h0);
        end
        check("rst_busy", 32'(busy), 32'h0);
        for (int i = 0; i < NREQ; i++) set_len(i, 3);
        rst = 1'b1;
        tick();
        check("first_gnt", 32'(gnt), 32'h1);
        check("first_q", 32'(q), 32'd3);
        req = '0;
        tick(); tick(); tick();
        check("first_q0", 32'(q), 32'd0);
        tick();
        check("first_done", 32'(done), 32'h1);
        check("first_busy", 32'(busy), 32'h0);

        // Single requester 2 with length 5
        req = 4'b0100;
        set_len(2, 5);
        tick();
        check("r2_gnt", 32'(gnt), 32'h4);
        check("r2_q5", 32'(q), 32'd5);
        check("r2_done_clr", 32'(done), 32'h0);
        req = '0;
        for (int v = 4; v >= 0; v--) begin
            tick();
            check("r2_q", 32'(q), 32'(v));
            check("r2_hold_gnt", 32'(gnt), 32'h4);
            check("r2_no_done", 32'(done), 32'h0);
        end
        tick();
        check("r2_done", 32'(done), 32'h4);
        check("r2_gnt_off", 32'(gnt), 32'h0);
        check("r2_busy_off", 32'(busy), 32'h0);
        tick();
        check("r2_done_pulse", 32'(done), 32'h0);

        // Reset mid-count at q=3
        req = 4'b0010;
        set_len(1, 6);
        tick();
        check("mid_gnt", 32'(gnt), 32'h2);
        req = '0;
        tick(); tick(); tick();
        check("mid_q3", 32'(q), 32'd3);
        rst = 1'b0;
        #1;
        check("mid_rst_q", 32'(q), 32'h0);
        check("mid_rst_gnt", 32'(gnt), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        tick();
        check("mid_rst_done", 32'(done), 32'h0);
        rst = 1'b1;

        // All requesting, all length 1: round-robin 0,1,2,3,0
        for (int i = 0; i < NREQ; i++) set_len(i, 1);
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_g = 4'b0001 << (g % 4);
            tick();
            check("rr_gnt", 32'(gnt), 32'(exp_g));
            check("rr_q1", 32'(q), 32'd1);
            check("rr_done_clr", 32'(done), 32'h0);
            tick();
            check("rr_q0", 32'(q), 32'd0);
            check("rr_gnt_hold", 32'(gnt), 32'(exp_g));
            tick();
            check("rr_done", 32'(done), 32'(exp_g));
            check("rr_gap", 32'(gnt), 32'h0);
        end
        req = '0;
        tick();
        check("rr_idle_gnt", 32'(gnt), 32'h0);
        check("rr_idle_done", 32'(done), 32'h0);

        // Zero length: done one cycle after grant
        req = 4'b0010;
        set_len(1, 0);
        tick();
        check("z_gnt", 32'(gnt), 32'h2);
        check("z_q", 32'(q), 32'h0);
        req = '0;
        tick();
        check("z_done", 32'(done), 32'h2);
        check("z_gnt_off", 32'(gnt), 32'h0);

        // Maximum length 255: done 256 cycles after grant, no wrap
        req = 4'b0010;
        set_len(1, 255);
        tick();
        check("max_gnt", 32'(gnt), 32'h2);
        check("max_q", 32'(q), 32'd255);
        req = '0;
        for (int v = 254; v >= 0; v--) begin
            tick();
            check("max_cnt", 32'(q), 32'(v));
        end
        check("max_no_early_done", 32'(done), 32'h0);
        tick();
        check("max_done", 32'(done), 32'h2);
        check("max_no_wrap", 32'(q), 32'h0);
        tick();
        check("max_q_hold", 32'(q), 32'h0);

`ifdef DOWN_CNT_SCHED_ABORT_EN
        // Abort by owner at q=4; non-owner abort ignored
        req = 4'b1000;
        set_len(3, 10);
        tick();
        check("ab_gnt", 32'(gnt), 32'h8);
        check("ab_q", 32'(q), 32'd10);
        req   = '0;
        abort = 4'b0001;
        for (int v = 9; v >= 4; v--) begin
            tick();
            check("ab_other_ignored", 32'(q), 32'(v));
            check("ab_gnt_hold", 32'(gnt), 32'h8);
        end
        abort = 4'b1001;
        tick();
        check("ab_gnt_off", 32'(gnt), 32'h0);
        check("ab_q0", 32'(q), 32'h0);
        check("ab_no_done", 32'(done), 32'h0);
        abort = '0;
        tick();
        check("ab_no_done_later", 32'(done), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
